a2_timer: RTL and testbench
===========================

# a2_timer

Time-pulse generator feeding the service-gate stage (A7). Divides the CLOCK into memory-cycle time slots T01–T12, each split into a read phase and a write phase. Drives the active-low slot and phase strobes (T01_…T12_, RT_, WT_, CT_, TT_) consumed by the service gates and crosspoint logic. Owns run/halt/standby sequencing: monitor stop, single-step start, standby entry/exit and GOJAM restart.

## Interface
- NSLOT, 12, slots per memory cycle; only 12 is supported. TCNT width is fixed at 4.
- CLOCK  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-low reset.
- GOJAM_  in  1  active-low restart request, sampled each edge.
- SBY  in  1  standby request, active high.
- MSTP  in  1  monitor stop, active high, level.
- MSTRT  in  1  single-step start, one-cycle pulse; honoured only in HALT.
- T01_…T12_  out  1 each  active-low one-hot slot strobes.
- RT_  out  1  read time; low in phase 0.
- CT_  out  1  clear time; low in phase 0.
- WT_  out  1  write time; low in phase 1.
- TT_  out  1  low in both phases of T12.
- MCT  out  1  high for the single cycle T12/phase 1.
- TCNT  out  4  current slot number 1–12; 0 when not running.
- RUNNING  out  1  high in RUN.

## Operation
- State: mode ∈ {RUN, HALT, STBY}; slot 1–12; phase 0/1; step_pending flag.
- All outputs are registered. Each edge computes the next state, and the outputs reflect it.
- Inactive output set: all T*_, RT_, CT_, WT_ and TT_ high; MCT=0, TCNT=0, RUNNING=0.
- Reset (rst=0 at an edge):
  - mode=RUN; internal slot=12, phase=1; step_pending=0.
  - Outputs take the inactive set.
  - First edge with rst=1: T01/phase 0.
- RUN advance:
  - phase 0→1 within a slot.
  - From phase 1: slot+1 and phase 0. T12/phase 1 wraps to T01/phase 0.
- End-of-cycle checks are evaluated only at the edge leaving T12/phase 1, in priority order:
  1. SBY=1 → STBY.
  2. MSTP=1 and step_pending=0 → HALT.
  3. step_pending=1 → clear step_pending, then HALT.
  4. Otherwise wrap to T01.
- A partial cycle is never truncated by SBY or MSTP.
- HALT:
  - Outputs take the inactive set.
  - MSTP=0 → next edge T01/phase 0 (RUN).
  - MSTRT=1 with MSTP=1 → next edge T01/phase 0 with step_pending=1. Exactly one full cycle runs, then HALT.
  - MSTRT outside HALT is ignored (not latched).
- STBY:
  - Outputs take the inactive set.
  - SBY=0 → next edge T01/phase 0 in RUN, subject to MSTP at the following cycle end.
- GOJAM_=0 at any edge, in any mode:
  - Next state is T01/phase 0 in RUN; step_pending cleared.
  - Overrides SBY, MSTP and MSTRT.
  - Held low → T01/phase 0 repeats each edge.
- Precedence: rst > GOJAM_ > end-of-cycle rules > MSTRT.

## Timing
- Slot = 2 CLOCK cycles; memory cycle = 24 cycles.
- Output latency: 1 edge from the qualifying input sample.
- MCT rises on the edge entering T12/phase 1 and falls on the next edge.
- HALT/STBY are entered on the edge after MCT. No strobe glitch; outputs go inactive in that same edge.
- Resume from HALT/STBY: first active output (T01_=0, RT_=0, CT_=0) one edge after the release condition.
- Exactly one T*_ is low in RUN; none is low in HALT or STBY.

## Structure
- Package a2_timer_pkg:
  - NSLOT=12.
  - mode_t enum {RUN, HALT, STBY}.
  - Phase constants PH_READ=0, PH_WRITE=1.
- Sub-module a2_tslot_ring: 12-bit one-hot ring with load-T01 and clear inputs. Top level holds the phase flop, mode FSM and step_pending.

## Test plan
- Reset release:
  - Stimulus: rst=0 for 3 edges, then 1.
  - Response: outputs inactive during reset. First edge gives T01_=0, RT_=0, CT_=0, TCNT=1. 24 edges later, T01 again; MCT high exactly once, at TCNT=12 with WT_=0, TT_=0.
- Monitor stop:
  - Stimulus: MSTP=1 asserted at TCNT=5.
  - Response: run continues to T12/phase 1, then HALT with all inactive and RUNNING=0. MSTP=0 → T01 on the next edge.
- Single step:
  - Stimulus: in HALT with MSTP=1, pulse MSTRT.
  - Response: exactly 24 active cycles and one MCT, then HALT. A second MSTRT pulse during the run has no effect.
- Standby:
  - Stimulus: SBY=1 and MSTP=1 both asserted at TCNT=9.
  - Response: STBY wins at cycle end. SBY=0 → one cycle runs, then HALT (MSTP still 1).
- GOJAM:
  - Stimulus: GOJAM_=0 for one edge at TCNT=7/phase 1; repeat in HALT and in STBY.
  - Response: each time, next state T01/phase 0 in RUN.
- Reset mid-step:
  - Stimulus: rst=0 at TCNT=6 during a single step.
  - Response: outputs inactive immediately; after release, free-run (step_pending cleared) unless MSTP=1.

Source files
------------

// File: rtl/a2_timer_pkg.sv
// Shared types and constants for the a2_timer time-pulse generator.
package a2_timer_pkg;

  localparam int unsigned NSLOT  = 12;
  localparam int unsigned TCNT_W = 4;

  localparam logic PH_READ  = 1'b0;
  localparam logic PH_WRITE = 1'b1;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    STBY = 2'd2
  } mode_t;

  // Registered strobe bundle driven to the service gates (active-low strobes).
  typedef struct packed {
    logic [NSLOT-1:0]  t_n;
    logic              rt_n;
    logic              ct_n;
    logic              wt_n;
    logic              tt_n;
    logic              mct;
    logic [TCNT_W-1:0] tcnt;
    logic              running;
  } strobe_t;

  localparam strobe_t STROBE_IDLE = '{
    t_n:     '1,
    rt_n:    1'b1,
    ct_n:    1'b1,
    wt_n:    1'b1,
    tt_n:    1'b1,
    mct:     1'b0,
    tcnt:    '0,
    running: 1'b0
  };

  // One-hot slot vector to slot number 1..NSLOT (0 when empty).
  function automatic logic [TCNT_W-1:0] slot_num(input logic [NSLOT-1:0] oh);
    slot_num = '0;
    for (int i = 0; i < NSLOT; i++) begin
      if (oh[i]) slot_num = TCNT_W'(i + 1);
    end
  endfunction

endpackage

// File: rtl/a2_tslot_ring.sv
// One-hot time-slot ring T01..T12 with load-T01, clear and advance controls.
module a2_tslot_ring
  import a2_timer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_t01,
  input  logic             clear,
  input  logic             adv,
  output logic [NSLOT-1:0] ring_nxt_c,
  output logic [NSLOT-1:0] ring
);

  // Next ring value is exported so the top can register strobes from it.
  always_comb begin
    ring_nxt_c = ring;
    if (load_t01) begin
      ring_nxt_c = NSLOT'(1);
    end else if (clear) begin
      ring_nxt_c = '0;
    end else if (adv) begin
      ring_nxt_c = {ring[NSLOT-2:0], ring[NSLOT-1]};
    end
  end

  // Reset parks the ring on the last slot so the first advance lands on T01.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ring <= {1'b1, {(NSLOT-1){1'b0}}};
    end else begin
      ring <= ring_nxt_c;
    end
  end

endmodule

// File: rtl/a2_timer.sv
// Time-pulse generator: slot/phase strobes plus run/halt/standby/step sequencing.
module a2_timer
  import a2_timer_pkg::*;
(
  input  logic                CLOCK,
  input  logic                rst,
  input  logic                GOJAM_,
  input  logic                SBY,
  input  logic                MSTP,
  input  logic                MSTRT,
  output logic                T01_,
  output logic                T02_,
  output logic                T03_,
  output logic                T04_,
  output logic                T05_,
  output logic                T06_,
  output logic                T07_,
  output logic                T08_,
  output logic                T09_,
  output logic                T10_,
  output logic                T11_,
  output logic                T12_,
  output logic                RT_,
  output logic                CT_,
  output logic                WT_,
  output logic                TT_,
  output logic                MCT,
  output logic [TCNT_W-1:0]   TCNT,
  output logic                RUNNING
);

  mode_t            mode;
  mode_t            mode_nxt;
  logic             phase;
  logic             phase_nxt;
  logic             step_pending;
  logic             step_pending_nxt;
  logic             ring_load;
  logic             ring_clear;
  logic             ring_adv;
  logic [NSLOT-1:0] ring;
  logic [NSLOT-1:0] ring_nxt;
  logic             last_slot;
  strobe_t          strb;
  strobe_t          strb_nxt;

  a2_tslot_ring u_ring (
    .clk        (CLOCK),
    .rst        (rst),
    .load_t01   (ring_load),
    .clear      (ring_clear),
    .adv        (ring_adv),
    .ring_nxt_c (ring_nxt),
    .ring       (ring)
  );

  assign last_slot = ring[NSLOT-1];

  // State register; strobes are registered from the next-state decode.
  always_ff @(posedge CLOCK) begin
    if (!rst) begin
      mode         <= RUN;
      phase        <= PH_WRITE;
      step_pending <= 1'b0;
      strb         <= STROBE_IDLE;
    end else begin
      mode         <= mode_nxt;
      phase        <= phase_nxt;
      step_pending <= step_pending_nxt;
      strb         <= strb_nxt;
    end
  end

  // Next-state: GOJAM first, then cycle-end decisions, then HALT/STBY release.
  always_comb begin
    mode_nxt         = mode;
    phase_nxt        = phase;
    step_pending_nxt = step_pending;
    ring_load        = 1'b0;
    ring_clear       = 1'b0;
    ring_adv         = 1'b0;

    if (!GOJAM_) begin
      mode_nxt         = RUN;
      phase_nxt        = PH_READ;
      step_pending_nxt = 1'b0;
      ring_load        = 1'b1;
    end else begin
      unique case (mode)
        RUN: begin
          if (phase == PH_READ) begin
            phase_nxt = PH_WRITE;
          end else if (!last_slot) begin
            phase_nxt = PH_READ;
            ring_adv  = 1'b1;
          end else if (SBY) begin
            mode_nxt   = STBY;
            ring_clear = 1'b1;
          end else if (MSTP && !step_pending) begin
            mode_nxt   = HALT;
            ring_clear = 1'b1;
          end else if (step_pending) begin
            mode_nxt         = HALT;
            step_pending_nxt = 1'b0;
            ring_clear       = 1'b1;
          end else begin
            phase_nxt = PH_READ;
            ring_load = 1'b1;
          end
        end
        HALT: begin
          if (!MSTP) begin
            mode_nxt  = RUN;
            phase_nxt = PH_READ;
            ring_load = 1'b1;
          end else if (MSTRT) begin
            mode_nxt         = RUN;
            phase_nxt        = PH_READ;
            step_pending_nxt = 1'b1;
            ring_load        = 1'b1;
          end
        end
        STBY: begin
          if (!SBY) begin
            mode_nxt  = RUN;
            phase_nxt = PH_READ;
            ring_load = 1'b1;
          end
        end
        default: begin
          mode_nxt  = RUN;
          phase_nxt = PH_READ;
          ring_load = 1'b1;
        end
      endcase
    end
  end

  // Strobe decode of the next state; everything idle outside RUN.
  always_comb begin
    strb_nxt = STROBE_IDLE;
    if (mode_nxt == RUN) begin
      strb_nxt.t_n     = ~ring_nxt;
      strb_nxt.rt_n    = (phase_nxt != PH_READ);
      strb_nxt.ct_n    = (phase_nxt != PH_READ);
      strb_nxt.wt_n    = (phase_nxt != PH_WRITE);
      strb_nxt.tt_n    = ~ring_nxt[NSLOT-1];
      strb_nxt.mct     = ring_nxt[NSLOT-1] && (phase_nxt == PH_WRITE);
      strb_nxt.tcnt    = slot_num(ring_nxt);
      strb_nxt.running = 1'b1;
    end
  end

  assign T01_    = strb.t_n[0];
  assign T02_    = strb.t_n[1];
  assign T03_    = strb.t_n[2];
  assign T04_    = strb.t_n[3];
  assign T05_    = strb.t_n[4];
  assign T06_    = strb.t_n[5];
  assign T07_    = strb.t_n[6];
  assign T08_    = strb.t_n[7];
  assign T09_    = strb.t_n[8];
  assign T10_    = strb.t_n[9];
  assign T11_    = strb.t_n[10];
  assign T12_    = strb.t_n[11];
  assign RT_     = strb.rt_n;
  assign CT_     = strb.ct_n;
  assign WT_     = strb.wt_n;
  assign TT_     = strb.tt_n;
  assign MCT     = strb.mct;
  assign TCNT    = strb.tcnt;
  assign RUNNING = strb.running;

endmodule

// File: tb/tb_a2_timer.sv
// Self-checking bench for a2_timer: vector table plus single-step counting sequence.
module tb_a2_timer;

  logic       CLOCK = 1'b0;
  logic       rst;
  logic       GOJAM_;
  logic       SBY;
  logic       MSTP;
  logic       MSTRT;
  logic       T01_, T02_, T03_, T04_, T05_, T06_;
  logic       T07_, T08_, T09_, T10_, T11_, T12_;
  logic       RT_, CT_, WT_, TT_, MCT, RUNNING;
  logic [3:0] TCNT;

  a2_timer dut (
    .CLOCK   (CLOCK),
    .rst     (rst),
    .GOJAM_  (GOJAM_),
    .SBY     (SBY),
    .MSTP    (MSTP),
    .MSTRT   (MSTRT),
    .T01_    (T01_),
    .T02_    (T02_),
    .T03_    (T03_),
    .T04_    (T04_),
    .T05_    (T05_),
    .T06_    (T06_),
    .T07_    (T07_),
    .T08_    (T08_),
    .T09_    (T09_),
    .T10_    (T10_),
    .T11_    (T11_),
    .T12_    (T12_),
    .RT_     (RT_),
    .CT_     (CT_),
    .WT_     (WT_),
    .TT_     (TT_),
    .MCT     (MCT),
    .TCNT    (TCNT),
    .RUNNING (RUNNING)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    logic r;
    logic g;
    logic s;
    logic m;
    logic st;
    int   tc;
    logic ph;
  } vec_t;

  vec_t vecs[$];
  int   m_slot;
  logic m_ph;
  int   checks   = 0;
  int   failures = 0;

  logic [21:0] obs;
  assign obs = {T12_, T11_, T10_, T09_, T08_, T07_, T06_, T05_, T04_, T03_, T02_, T01_,
                RT_, CT_, WT_, TT_, MCT, TCNT, RUNNING};

  task automatic add(input logic r, input logic g, input logic s, input logic m,
                     input logic st, input int tc, input logic ph);
    vec_t v;
    v.r = r; v.g = g; v.s = s; v.m = m; v.st = st; v.tc = tc; v.ph = ph;
    vecs.push_back(v);
    m_slot = tc;
    m_ph   = ph;
  endtask

  // Appends n RUN edges, stepping the expected slot/phase sequence.
  task automatic add_run(input int n, input logic g, input logic s, input logic m,
                         input logic st);
    int   ns;
    logic np;
    for (int k = 0; k < n; k++) begin
      if (m_slot == 0)      begin ns = 1;          np = 1'b0; end
      else if (!m_ph)       begin ns = m_slot;     np = 1'b1; end
      else if (m_slot == 12) begin ns = 1;         np = 1'b0; end
      else                  begin ns = m_slot + 1; np = 1'b0; end
      add(1'b1, g, s, m, st, ns, np);
    end
  endtask

  function automatic logic [21:0] expect_of(input int tc, input logic ph);
    logic [11:0] t;
    logic        act;
    t   = 12'hFFF;
    act = (tc != 0);
    if (act) t[tc-1] = 1'b0;
    return {t, act ? ph : 1'b1, act ? ph : 1'b1, act ? ~ph : 1'b1,
            !(tc == 12), (tc == 12) && ph, 4'(tc), act};
  endfunction

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  int          n_act;
  int          n_mct;
  int          n_tt;
  int          wait_cnt;
  logic [21:0] exp_v;

  initial begin
    rst = 1'b0; GOJAM_ = 1'b1; SBY = 1'b0; MSTP = 1'b0; MSTRT = 1'b0;
    m_slot = 0; m_ph = 1'b0;

    // Reset held, then a full free-running memory cycle and the wrap.
    for (int k = 0; k < 3; k++) add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    add_run(25, 1'b1, 1'b0, 1'b0, 1'b0);
    // Monitor stop raised at TCNT=5, halt after T12, release.
    add_run(8, 1'b1, 1'b0, 1'b0, 1'b0);
    add_run(15, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    add_run(1, 1'b1, 1'b0, 1'b0, 1'b0);
    // Into HALT, then single step with an ignored second MSTRT.
    add_run(23, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    add_run(1, 1'b1, 1'b0, 1'b1, 1'b1);
    add_run(9, 1'b1, 1'b0, 1'b1, 1'b0);
    add_run(1, 1'b1, 1'b0, 1'b1, 1'b1);
    add_run(13, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    // Step with MSTP dropped mid-cycle still halts at cycle end.
    add_run(1, 1'b1, 1'b0, 1'b1, 1'b1);
    add_run(10, 1'b1, 1'b0, 1'b1, 1'b0);
    add_run(13, 1'b1, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    add_run(1, 1'b1, 1'b0, 1'b0, 1'b0);
    // SBY and MSTP at TCNT=9: standby wins; one cycle after release, then HALT.
    add_run(16, 1'b1, 1'b0, 1'b0, 1'b0);
    add_run(7, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    add_run(1, 1'b1, 1'b0, 1'b1, 1'b0);
    add_run(23, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    // GOJAM in HALT, at T07/phase 1 (held three edges), and in STBY.
    add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0);
    add_run(13, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0);
    add_run(1, 1'b1, 1'b0, 1'b0, 1'b0);
    add_run(22, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    add(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1'b0);
    add_run(1, 1'b1, 1'b1, 1'b0, 1'b0);
    // Reset at TCNT=6 during a step; release with MSTP=0 free-runs.
    add_run(22, 1'b1, 1'b0, 1'b1, 1'b0);
    add(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    add_run(1, 1'b1, 1'b0, 1'b1, 1'b1);
    add_run(10, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) add(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    add_run(30, 1'b1, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      rst = vecs[i].r; GOJAM_ = vecs[i].g; SBY = vecs[i].s;
      MSTP = vecs[i].m; MSTRT = vecs[i].st;
      tick();
      exp_v = expect_of(vecs[i].tc, vecs[i].ph);
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL vec[%0d] strobes: got %h expected %h (tcnt %0d ph %0d)",
                 i, obs, exp_v, vecs[i].tc, vecs[i].ph);
      end
    end

    // Bring the free-running timer to HALT via MSTP within a bounded wait.
    rst = 1'b1; GOJAM_ = 1'b1; SBY = 1'b0; MSTRT = 1'b0; MSTP = 1'b1;
    wait_cnt = 0;
    do begin
      tick();
      wait_cnt++;
    end while (RUNNING !== 1'b0 && wait_cnt < 40);
    checks++;
    if (RUNNING !== 1'b0) begin
      failures++;
      $display("FAIL halt_wait: RUNNING=%b after %0d edges, expected 0", RUNNING, wait_cnt);
    end

    // Single step: count active cycles, MCT pulses and TT_ low cycles.
    tick();
    n_act = 0; n_mct = 0; n_tt = 0;
    MSTRT = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      MSTRT = 1'b0;
      if (RUNNING === 1'b1) n_act++;
      if (MCT === 1'b1)     n_mct++;
      if (TT_ === 1'b0)     n_tt++;
    end
    checks++;
    if (n_act != 24) begin
      failures++;
      $display("FAIL step_active: got %0d cycles, expected 24", n_act);
    end
    checks++;
    if (n_mct != 1) begin
      failures++;
      $display("FAIL step_mct: got %0d pulses, expected 1", n_mct);
    end
    checks++;
    if (n_tt != 2) begin
      failures++;
      $display("FAIL step_tt: got %0d cycles, expected 2", n_tt);
    end
    checks++;
    if (obs !== expect_of(0, 1'b0)) begin
      failures++;
      $display("FAIL step_end_halt: got %h expected %h", obs, expect_of(0, 1'b0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
